// File: rtl/slice_cfg_pkg.sv
// Purpose: shared types, constants and helpers for the slice config loader.
// Latency: n/a (declarations only).
// Backpressure: n/a. The CHECK state exists only when SLICE_CFG_CRC_EN is defined.
package slice_cfg_pkg;

  // CRC-8 generator polynomial x^8 + x^2 + x + 1 (implicit x^8).
  localparam logic [7:0] CRC8_POLY = 8'h07;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SHIFT = 3'd2,
`ifdef SLICE_CFG_CRC_EN
    ST_CHECK = 3'd3,
`endif
    ST_DONE  = 3'd4
  } state_e;

  // Number of config words needed to cover a chain (last word may be partial).
  function automatic int words_for(input int chain_len, input int word_w);
    return (chain_len + word_w - 1) / word_w;
  endfunction

endpackage

// File: rtl/slice_cfg_loader_if.sv
// Purpose: control, word-stream and serial-chain signals of the slice config loader.
// Latency: n/a (wiring only).
// Backpressure: cfg_valid/cfg_ready word handshake; slave = loader, master = word source/controller.
interface slice_cfg_loader_if #(
  parameter int WORD_W = 8
);
  logic              start;      // pulse: begin a load
  logic              abort;      // cancel an in-progress load
  logic [WORD_W-1:0] cfg_data;   // config word, LSB shifted first
  logic              cfg_valid;  // cfg_data valid
  logic              cfg_ready;  // loader accepts a word
  logic              cfg_bit;    // serial bit to slice config_in chain
  logic              cfg_cen;    // slice shift enable
  logic              busy;       // not IDLE/DONE
  logic              done;       // load complete, held until next start
  logic              err;        // CRC mismatch

  modport slave (
    input  start, abort, cfg_data, cfg_valid,
    output cfg_ready, cfg_bit, cfg_cen, busy, done, err
  );

  modport master (
    output start, abort, cfg_data, cfg_valid,
    input  cfg_ready, cfg_bit, cfg_cen, busy, done, err
  );
endinterface

// File: rtl/slice_cfg_loader_crc8.sv
// Purpose: combinational CRC-8 (poly CRC8_POLY) update over one data word, fed MSB-first.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; caller decides when to register the result.
// Ports: crc_in (running CRC), data_in (word), crc_out (updated CRC).
module cfg_crc8
  import slice_cfg_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [7:0]        crc_in,
  input  logic [DATA_W-1:0] data_in,
  output logic [7:0]        crc_out
);

  logic [7:0] c;
  logic       fb;

  always_comb begin
    c  = crc_in;
    fb = 1'b0;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      fb = c[7] ^ data_in[i];
      c  = {c[6:0], 1'b0};
      if (fb) begin
        c = c ^ CRC8_POLY;
      end
    end
    crc_out = c;
  end

endmodule

// File: rtl/slice_cfg_loader.sv
// Purpose: turns a stream of config words into the serial slice config chain (LSB-first).
// Latency: bit0 of a word appears with cfg_cen=1 one cycle after its transfer; done one cycle after the last bit.
// Backpressure: cfg_ready only in LOAD (and CHECK); a stalled source just holds cfg_cen low.
// Ports: cclk, rst_n (async active-low) plus bus (slice_cfg_loader_if.slave).
// Optional: define SLICE_CFG_CRC_EN to add a trailing CRC-8 word checked in a CHECK state.
module slice_cfg_loader
  import slice_cfg_pkg::*;
#(
  parameter int WORD_W    = 8,
  parameter int CHAIN_LEN = 139
) (
  input  logic               cclk,
  input  logic               rst_n,
  slice_cfg_loader_if.slave  bus
);

  localparam int RW = $clog2(CHAIN_LEN + 1);
  localparam int CW = $clog2(WORD_W + 1);

  state_e            state_q, state_d;
  logic [RW-1:0]     remaining_q, remaining_d;  // chain bits still to emit
  logic [CW-1:0]     bitcnt_q, bitcnt_d;        // bits of current word still to emit after the one on cfg_bit
  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic              cfg_bit_q, cfg_bit_d;
  logic              cfg_cen_q, cfg_cen_d;
  logic              done_q, done_d;

  logic              busy;
  logic              cfg_ready;
  logic [CW-1:0]     word_bits;                 // bits taken from the word being transferred

`ifdef SLICE_CFG_CRC_EN
  logic [7:0]        crc_q, crc_d, crc_next;
  logic              err_q, err_d;

  cfg_crc8 #(
    .DATA_W (WORD_W)
  ) u_crc (
    .crc_in  (crc_q),
    .data_in (bus.cfg_data),
    .crc_out (crc_next)
  );
`endif

  assign busy = (state_q != ST_IDLE) && (state_q != ST_DONE);

`ifdef SLICE_CFG_CRC_EN
  assign cfg_ready = (state_q == ST_LOAD) || (state_q == ST_CHECK);
`else
  assign cfg_ready = (state_q == ST_LOAD);
`endif

  // Last word of the chain is usually partial; its high bits are dropped.
  assign word_bits = (int'(remaining_q) < WORD_W) ? CW'(remaining_q) : CW'(WORD_W);

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    bitcnt_d    = bitcnt_q;
    shreg_d     = shreg_q;
    cfg_bit_d   = 1'b0;
    cfg_cen_d   = 1'b0;
    done_d      = done_q;
`ifdef SLICE_CFG_CRC_EN
    crc_d       = crc_q;
    err_d       = err_q;
`endif

    if (bus.abort) begin
      // Abort wins over start and over a word offered in the same cycle.
      if (busy) begin
        state_d = ST_IDLE;
        done_d  = 1'b0;
      end
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            state_d     = ST_LOAD;
            done_d      = 1'b0;
            remaining_d = RW'(CHAIN_LEN);
`ifdef SLICE_CFG_CRC_EN
            err_d       = 1'b0;
            crc_d       = 8'h00;
`endif
          end
        end

        ST_LOAD: begin
          if (bus.cfg_valid) begin
            // bit0 goes straight to the output register; the rest are queued.
            state_d     = ST_SHIFT;
            cfg_bit_d   = bus.cfg_data[0];
            cfg_cen_d   = 1'b1;
            shreg_d     = bus.cfg_data >> 1;
            bitcnt_d    = word_bits - CW'(1);
            remaining_d = remaining_q - RW'(1);
`ifdef SLICE_CFG_CRC_EN
            crc_d       = crc_next;
`endif
          end
        end

        ST_SHIFT: begin
          if (bitcnt_q != '0) begin
            cfg_bit_d   = shreg_q[0];
            cfg_cen_d   = 1'b1;
            shreg_d     = shreg_q >> 1;
            bitcnt_d    = bitcnt_q - CW'(1);
            remaining_d = remaining_q - RW'(1);
          end else if (remaining_q != '0) begin
            state_d = ST_LOAD;
          end else begin
`ifdef SLICE_CFG_CRC_EN
            state_d = ST_CHECK;
`else
            state_d = ST_DONE;
            done_d  = 1'b1;
`endif
          end
        end

`ifdef SLICE_CFG_CRC_EN
        ST_CHECK: begin
          if (bus.cfg_valid) begin
            err_d   = (bus.cfg_data[7:0] != crc_q);
            done_d  = 1'b1;
            state_d = ST_DONE;
          end
        end
`endif

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge cclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      bitcnt_q    <= '0;
      shreg_q     <= '0;
      cfg_bit_q   <= 1'b0;
      cfg_cen_q   <= 1'b0;
      done_q      <= 1'b0;
`ifdef SLICE_CFG_CRC_EN
      crc_q       <= 8'h00;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      bitcnt_q    <= bitcnt_d;
      shreg_q     <= shreg_d;
      cfg_bit_q   <= cfg_bit_d;
      cfg_cen_q   <= cfg_cen_d;
      done_q      <= done_d;
`ifdef SLICE_CFG_CRC_EN
      crc_q       <= crc_d;
      err_q       <= err_d;
`endif
    end
  end

  assign bus.cfg_ready = cfg_ready;
  assign bus.cfg_bit   = cfg_bit_q;
  assign bus.cfg_cen   = cfg_cen_q;
  assign bus.busy      = busy;
  assign bus.done      = done_q;
`ifdef SLICE_CFG_CRC_EN
  assign bus.err       = err_q;
`else
  assign bus.err       = 1'b0;
`endif

endmodule

// File: tb/tb_slice_cfg_loader.sv
module tb_slice_cfg_loader;
  import slice_cfg_pkg::*;

  localparam int WORD_W    = 8;
  localparam int CHAIN_LEN = 139;
  localparam int NW        = words_for(CHAIN_LEN, WORD_W);

  logic cclk  = 1'b0;
  logic rst_n = 1'b0;

  slice_cfg_loader_if #(.WORD_W(WORD_W)) bus ();

  slice_cfg_loader #(
    .WORD_W    (WORD_W),
    .CHAIN_LEN (CHAIN_LEN)
  ) dut (
    .cclk  (cclk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 cclk = ~cclk;

  int n_cmp = 0;
  int n_bad = 0;

  // Chain monitor, sampled on the falling edge.
  int   cyc          = 0;
  int   n_bits       = 0;
  int   last_cen_cyc = -1;
  logic bits [0:2047];

  always @(negedge cclk) begin
    cyc = cyc + 1;
    if (bus.cfg_cen === 1'b1) begin
      if (n_bits < 2048) bits[n_bits] = bus.cfg_bit;
      n_bits       = n_bits + 1;
      last_cen_cyc = cyc;
    end
  end

  logic [7:0] tbl [0:NW-1];

  // Measurements recorded by the stimulus helpers.
  logic first_cen, first_bit, stall_rdy;
  int   stall_cens;

  task automatic tick;
    @(posedge cclk);
    #1;
  endtask

  task automatic do_start;
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
  endtask

  // Offer one word; returns just after the edge that transferred it.
  task automatic send_word(input logic [7:0] w, output bit ok);
    ok = 1'b0;
    bus.cfg_data  = w;
    bus.cfg_valid = 1'b1;
    for (int t = 0; t < 64; t++) begin
      @(negedge cclk);
      if (bus.cfg_ready === 1'b1) begin
        tick;
        ok = 1'b1;
        break;
      end
    end
    bus.cfg_valid = 1'b0;
  endtask

  task automatic wait_load(output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 64; t++) begin
      @(negedge cclk);
      if (bus.cfg_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    tick;
  endtask

  function automatic logic [7:0] crc_model();
    logic [7:0] c;
    logic [7:0] w;
    logic       fb;
    c = 8'h00;
    for (int i = 0; i < NW; i++) begin
      w = tbl[i];
      for (int b = 7; b >= 0; b--) begin
        fb = c[7] ^ w[b];
        c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
      end
    end
    return c;
  endfunction

  task automatic load_words(input int stall_after, input int start_after,
                            input logic [7:0] crc_flip, output bit ok);
    bit w_ok;
    bit l_ok;
    ok = 1'b1;
    for (int i = 0; i < NW; i++) begin
      send_word(tbl[i], w_ok);
      if (!w_ok) ok = 1'b0;
      if (i == 0) begin
        first_cen = bus.cfg_cen;
        first_bit = bus.cfg_bit;
      end
      if (i == start_after) begin
        tick;
        do_start;
      end
      if (i == stall_after) begin
        wait_load(l_ok);
        if (!l_ok) ok = 1'b0;
        stall_cens = n_bits;
        repeat (5) tick;
        stall_cens = n_bits - stall_cens;
        stall_rdy  = bus.cfg_ready;
      end
    end
`ifdef SLICE_CFG_CRC_EN
    send_word(crc_model() ^ crc_flip, w_ok);
    if (!w_ok) ok = 1'b0;
`else
    if (crc_flip != 8'h00) ok = 1'b0;
`endif
  endtask

  task automatic wait_done(output int c, output bit ok);
    ok = 1'b0;
    c  = -1;
    for (int t = 0; t < 100; t++) begin
      if (bus.done === 1'b1) begin
        ok = 1'b1;
        c  = cyc;
        break;
      end
      tick;
    end
  endtask

  function automatic int bit_errors(input int base);
    int   n;
    logic [7:0] w;
    n = 0;
    for (int k = 0; k < CHAIN_LEN; k++) begin
      w = tbl[k / WORD_W];
      if (bits[base + k] !== w[k % WORD_W]) n++;
    end
    return n;
  endfunction

  task automatic test_reset;
    bus.start = 1'b0; bus.abort = 1'b0; bus.cfg_valid = 1'b0; bus.cfg_data = '0;
    rst_n = 1'b0;
    tick; tick;
    n_cmp++; if (bus.cfg_ready !== 1'b0) begin n_bad++; $display("FAIL reset_cfg_ready got=%b exp=0", bus.cfg_ready); end
    n_cmp++; if (bus.cfg_cen !== 1'b0)   begin n_bad++; $display("FAIL reset_cfg_cen got=%b exp=0", bus.cfg_cen); end
    n_cmp++; if (bus.cfg_bit !== 1'b0)   begin n_bad++; $display("FAIL reset_cfg_bit got=%b exp=0", bus.cfg_bit); end
    n_cmp++; if (bus.busy !== 1'b0)      begin n_bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    n_cmp++; if (bus.done !== 1'b0)      begin n_bad++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    n_cmp++; if (bus.err !== 1'b0)       begin n_bad++; $display("FAIL reset_err got=%b exp=0", bus.err); end
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_full_load;
    int base, dc;
    bit ok, dok;
    for (int i = 0; i < NW; i++) tbl[i] = 8'hA5;
    base = n_bits;
    do_start;
    n_cmp++; if ({bus.busy, bus.cfg_ready} !== 2'b11) begin n_bad++; $display("FAIL full_load_state got=%b exp=11", {bus.busy, bus.cfg_ready}); end
    load_words(-1, -1, 8'h00, ok);
    wait_done(dc, dok);
    n_cmp++; if ({ok, dok} !== 2'b11) begin n_bad++; $display("FAIL full_load_handshake got=%b exp=11", {ok, dok}); end
    n_cmp++; if ({first_cen, first_bit} !== 2'b11) begin n_bad++; $display("FAIL full_load_bit0 got=%b exp=11", {first_cen, first_bit}); end
    n_cmp++; if (n_bits - base !== CHAIN_LEN) begin n_bad++; $display("FAIL full_load_count got=%0d exp=%0d", n_bits - base, CHAIN_LEN); end
    n_cmp++; if (bit_errors(base) !== 0) begin n_bad++; $display("FAIL full_load_bits got=%0d bad exp=0", bit_errors(base)); end
    n_cmp++; if ({bits[base+136], bits[base+137], bits[base+138]} !== 3'b101) begin n_bad++;
      $display("FAIL full_load_tail got=%b exp=101", {bits[base+136], bits[base+137], bits[base+138]}); end
`ifndef SLICE_CFG_CRC_EN
    // done first seen just after the edge that ends the last bit's cycle.
    n_cmp++; if (dc !== last_cen_cyc) begin n_bad++; $display("FAIL full_load_done_timing got=%0d exp=%0d", dc, last_cen_cyc); end
`endif
    repeat (5) tick;
    n_cmp++; if ({bus.done, bus.cfg_ready, bus.busy, bus.err, bus.cfg_cen} !== 5'b10000) begin n_bad++;
      $display("FAIL full_load_hold_done got=%b exp=10000", {bus.done, bus.cfg_ready, bus.busy, bus.err, bus.cfg_cen}); end
  endtask

  task automatic test_stall;
    int base, dc;
    bit ok, dok;
    for (int i = 0; i < NW; i++) tbl[i] = 8'(i * 37 + 11);
    base = n_bits;
    do_start;
    load_words(8, -1, 8'h00, ok);
    wait_done(dc, dok);
    n_cmp++; if ({ok, dok} !== 2'b11) begin n_bad++; $display("FAIL stall_handshake got=%b exp=11", {ok, dok}); end
    n_cmp++; if (stall_cens !== 0) begin n_bad++; $display("FAIL stall_cen got=%0d exp=0", stall_cens); end
    n_cmp++; if (stall_rdy !== 1'b1) begin n_bad++; $display("FAIL stall_ready got=%b exp=1", stall_rdy); end
    n_cmp++; if (n_bits - base !== CHAIN_LEN) begin n_bad++; $display("FAIL stall_count got=%0d exp=%0d", n_bits - base, CHAIN_LEN); end
    n_cmp++; if (bit_errors(base) !== 0) begin n_bad++; $display("FAIL stall_bits got=%0d bad exp=0", bit_errors(base)); end
  endtask

  task automatic test_abort;
    int base;
    bit ok, w_ok;
    ok = 1'b1;
    base = n_bits;
    do_start;
    for (int i = 0; i < 4; i++) begin
      send_word(8'h3C, w_ok);
      if (!w_ok) ok = 1'b0;
    end
    wait_load(w_ok);
    if (!w_ok) ok = 1'b0;
    bus.abort = 1'b1; bus.start = 1'b1; bus.cfg_valid = 1'b1; bus.cfg_data = 8'hFF;
    tick;
    bus.abort = 1'b0; bus.start = 1'b0; bus.cfg_valid = 1'b0;
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL abort_handshake got=%b exp=1", ok); end
    n_cmp++; if ({bus.busy, bus.done, bus.cfg_cen, bus.cfg_ready} !== 4'b0000) begin n_bad++;
      $display("FAIL abort_idle got=%b exp=0000", {bus.busy, bus.done, bus.cfg_cen, bus.cfg_ready}); end
    repeat (10) tick;
    n_cmp++; if (n_bits - base !== 32) begin n_bad++; $display("FAIL abort_count got=%0d exp=32", n_bits - base); end
    n_cmp++; if ({bus.busy, bus.done} !== 2'b00) begin n_bad++; $display("FAIL abort_stays_idle got=%b exp=00", {bus.busy, bus.done}); end
  endtask

  task automatic test_reset_mid_shift;
    int base, dc;
    bit ok, dok, w_ok;
    do_start;
    send_word(8'hFF, w_ok);
    send_word(8'hFF, w_ok);
    tick; tick;
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({bus.busy, bus.cfg_cen, bus.cfg_bit, bus.cfg_ready, bus.done, bus.err} !== 6'b000000) begin n_bad++;
      $display("FAIL rst_mid_async got=%b exp=000000", {bus.busy, bus.cfg_cen, bus.cfg_bit, bus.cfg_ready, bus.done, bus.err}); end
    tick;
    rst_n = 1'b1;
    tick;
    for (int i = 0; i < NW; i++) tbl[i] = 8'(255 - i * 13);
    base = n_bits;
    do_start;
    load_words(-1, -1, 8'h00, ok);
    wait_done(dc, dok);
    n_cmp++; if ({ok, dok} !== 2'b11) begin n_bad++; $display("FAIL rst_mid_reload got=%b exp=11", {ok, dok}); end
    n_cmp++; if (n_bits - base !== CHAIN_LEN) begin n_bad++; $display("FAIL rst_mid_count got=%0d exp=%0d", n_bits - base, CHAIN_LEN); end
    n_cmp++; if (bit_errors(base) !== 0) begin n_bad++; $display("FAIL rst_mid_bits got=%0d bad exp=0", bit_errors(base)); end
  endtask

  task automatic test_start_in_shift;
    int base, dc;
    bit ok, dok;
    for (int i = 0; i < NW; i++) tbl[i] = 8'(i * 17);
    base = n_bits;
    do_start;
    load_words(-1, 2, 8'h00, ok);
    wait_done(dc, dok);
    n_cmp++; if ({ok, dok} !== 2'b11) begin n_bad++; $display("FAIL start_shift_done got=%b exp=11", {ok, dok}); end
    n_cmp++; if (n_bits - base !== CHAIN_LEN) begin n_bad++; $display("FAIL start_shift_count got=%0d exp=%0d", n_bits - base, CHAIN_LEN); end
    n_cmp++; if (bit_errors(base) !== 0) begin n_bad++; $display("FAIL start_shift_bits got=%0d bad exp=0", bit_errors(base)); end
  endtask

`ifdef SLICE_CFG_CRC_EN
  task automatic test_crc;
    int dc;
    bit ok, dok;
    for (int i = 0; i < NW; i++) tbl[i] = 8'h00;
    do_start;
    load_words(-1, -1, 8'h00, ok);
    wait_done(dc, dok);
    n_cmp++; if ({ok, dok, bus.err} !== 3'b110) begin n_bad++; $display("FAIL crc_good got=%b exp=110", {ok, dok, bus.err}); end
    do_start;
    load_words(-1, -1, 8'h01, ok);
    wait_done(dc, dok);
    n_cmp++; if ({ok, dok, bus.err} !== 3'b111) begin n_bad++; $display("FAIL crc_bad got=%b exp=111", {ok, dok, bus.err}); end
    do_start;
    n_cmp++; if ({bus.err, bus.done} !== 2'b00) begin n_bad++; $display("FAIL crc_clear_on_start got=%b exp=00", {bus.err, bus.done}); end
    bus.abort = 1'b1;
    tick;
    bus.abort = 1'b0;
  endtask
`endif

  initial begin
    bus.start = 1'b0; bus.abort = 1'b0; bus.cfg_valid = 1'b0; bus.cfg_data = '0;
    first_cen = 1'b0; first_bit = 1'b0; stall_rdy = 1'b0; stall_cens = -1;
    test_reset;
    test_full_load;
    test_stall;
    test_abort;
    test_reset_mid_shift;
    test_start_in_shift;
`ifdef SLICE_CFG_CRC_EN
    test_crc;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
